// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and the external ALU.
// State encodings, ALU function codes and the per-state ALU control bundle.
package alu_mul_seq_pkg;

    localparam int MUL_W = 16;
    localparam int MUL_STEPS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mul_state_t;

    localparam logic [4:0] ALU_F_NOP         = 5'h00;
    localparam logic [4:0] ALU_F_ADD         = 5'h09;
    localparam logic [4:0] ALU_F_SHIFT_RIGHT = 5'h14;

    typedef struct packed {
        logic [4:0] f;
        logic       notaluoe;
        logic       notshiftoe;
    } alu_ctrl_t;

    // ALU controls presented while the FSM sits in a given state.
    function automatic alu_ctrl_t alu_ctrl(input mul_state_t s);
        alu_ctrl_t c;
        c = '{f: ALU_F_NOP, notaluoe: 1'b1, notshiftoe: 1'b1};
        unique case (1'b1)
            (s == ADD): begin
                c.f        = ALU_F_ADD;
                c.notaluoe = 1'b0;
            end
            (s == SHIFT): begin
                c.f          = ALU_F_SHIFT_RIGHT;
                c.notshiftoe = 1'b0;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 16x16->32 shift/add multiplier driving an external ALU.
// ALU controls are registered from the next state so they line up with it.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    output logic        alu_csel,
    output logic        alu_ucin,
    output logic        alu_notALUOE,
    output logic        alu_notShiftOE,
    input  logic [15:0] alu_y,
    input  logic        alu_cout,
    input  logic        alu_zout
);

    mul_state_t state;
    mul_state_t nxt;
    alu_ctrl_t  nctl;

    logic [15:0] hi;
    logic [15:0] lo;
    logic [15:0] mcand;
    logic        c;
    logic [4:0]  count;
    logic        last;

    logic unused;
    assign unused = alu_zout;

    assign alu_a    = hi;
    assign alu_b    = mcand;
    assign alu_csel = 1'b0;
    assign alu_ucin = 1'b0;

    // The sixteenth SHIFT is the one that finishes the product.
    assign last = (count == 5'(MUL_STEPS - 1));

    // Next state: after a SHIFT the new lo[0] is the current lo[1].
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (start) nxt = op_b[0] ? ADD : SHIFT;
            ADD:   nxt = SHIFT;
            SHIFT: begin
                if (last)       nxt = DONE;
                else if (lo[1]) nxt = ADD;
                else            nxt = SHIFT;
            end
            DONE:  nxt = IDLE;
        endcase
        nctl = alu_ctrl(nxt);
    end

    // Datapath registers, status flags and registered ALU controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hi             <= '0;
            lo             <= '0;
            mcand          <= '0;
            c              <= 1'b0;
            count          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            product        <= '0;
            alu_f          <= ALU_F_NOP;
            alu_notALUOE   <= 1'b1;
            alu_notShiftOE <= 1'b1;
        end else begin
            state          <= nxt;
            alu_f          <= nctl.f;
            alu_notALUOE   <= nctl.notaluoe;
            alu_notShiftOE <= nctl.notshiftoe;
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= op_a;
                        lo    <= op_b;
                        hi    <= '0;
                        c     <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                ADD: begin
                    hi <= alu_y;
                    c  <= alu_cout;
                end
                SHIFT: begin
                    hi    <= {c, alu_y[14:0]};
                    lo    <= {alu_cout, lo[15:1]};
                    c     <= 1'b0;
                    count <= count + 5'd1;
                    if (last) begin
                        done    <= 1'b1;
                        product <= {c, alu_y[14:0], alu_cout, lo[15:1]};
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
